// File: rtl/pool_pack_pkg.sv
// Shared pooling/packing constants and state type.
// Also consumed by the fully-connected stage for pool_lin sizing.
package pool_pack_pkg;

  localparam int DW     = 8;
  localparam int IN_W   = 6;
  localparam int CH     = 3;
  localparam int POOL_W = IN_W / 2;
  localparam int SLOTS  = CH * POOL_W * POOL_W;
  localparam int LIN_W  = SLOTS * DW;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

endpackage

// File: rtl/max2_s8.sv
// Combinational signed two-input maximum.
// Exact over the full two's-complement range.
module max2_s8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = ($signed(a) > $signed(b)) ? a : b;

endmodule

// File: rtl/pool_pack.sv
// 2x2 stride-2 signed max pooling of a streamed feature map,
// packed into one flat vector for the fully-connected stage.
module pool_pack #(
  parameter int DW   = pool_pack_pkg::DW,
  parameter int IN_W = pool_pack_pkg::IN_W,
  parameter int CH   = pool_pack_pkg::CH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DW-1:0]                        in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CH*(IN_W/2)*(IN_W/2)*DW-1:0]   pool_lin
);

  import pool_pack_pkg::state_t;
  import pool_pack_pkg::COLLECT;
  import pool_pack_pkg::FULL;

  localparam int PW  = IN_W / 2;
  localparam int NS  = CH * PW * PW;
  localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int HW  = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [CW-1:0] C_MAX = CW'(IN_W - 1);
  localparam logic [HW-1:0] H_MAX = HW'(CH - 1);

  state_t state, state_n;

  logic [CW-1:0] col, row;
  logic [HW-1:0] ch;
  logic [DW-1:0] pair;
  logic [DW-1:0] rowbuf [PW];

  logic          accept;
  logic          last;
  logic [DW-1:0] rb_sel;
  logic [DW-1:0] hmax;
  logic [DW-1:0] vmax;
  int            hc;
  int            slot;

  max2_s8 #(.W(DW)) u_hmax (
    .a (pair),
    .b (in_data),
    .y (hmax)
  );

  max2_s8 #(.W(DW)) u_vmax (
    .a (rb_sel),
    .b (hmax),
    .y (vmax)
  );

  assign accept = in_valid && in_ready;
  assign last   = (ch == H_MAX) && (row == C_MAX)
               && (col == C_MAX);

  always_comb begin
    hc     = int'(col) >> 1;
    slot   = int'(ch) * PW * PW
           + (int'(row) >> 1) * PW + hc;
    rb_sel = '0;
    for (int j = 0; j < PW; j++) begin
      if (j == hc) rb_sel = rowbuf[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = !rst;
        if (accept && last) state_n = FULL;
      end
      FULL: begin
        out_valid = !rst;
        if (out_ready) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  // Counters wrap on the last beat, so FULL always holds zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      ch   <= '0;
      pair <= '0;
      for (int j = 0; j < PW; j++) rowbuf[j] <= '0;
    end else if (accept) begin
      if (col == C_MAX) begin
        col <= '0;
        if (row == C_MAX) begin
          row <= '0;
          ch  <= (ch == H_MAX) ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
      if (!col[0]) begin
        pair <= in_data;
      end else if (!row[0]) begin
        for (int j = 0; j < PW; j++) begin
          if (j == hc) rowbuf[j] <= hmax;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pool_lin <= '0;
    end else if (accept && col[0] && row[0]) begin
      for (int s = 0; s < NS; s++) begin
        if (s == slot) pool_lin[s*DW +: DW] <= vmax;
      end
    end
  end

endmodule

// File: doc/pool_pack.md
POOL_PACK -- requirements
Module: pool_pack

Interface
REQ-001 The block SHALL have parameter DW, default 8: signed pixel width in bits.
REQ-002 The block SHALL have parameter IN_W, default 6: input feature-map side length, even.
REQ-003 The block SHALL have parameter CH, default 3: channel count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, DW bits: signed two's-complement conv pixel.
REQ-009 The block SHALL have port out_valid, output, 1 bit: pool_lin holds a complete pooled volume.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes pool_lin.
REQ-011 The block SHALL have port pool_lin, output, CH*(IN_W/2)^2*DW bits (216 at defaults): packed pooled volume for the fully-connected stage.

Function
REQ-012 Beat SHALL be accepted only when in_valid && in_ready.
REQ-013 Input order SHALL be channel-major (ch 0..CH-1), then row 0..IN_W-1, then col 0..IN_W-1; one pixel per beat.
REQ-014 Pooling SHALL be 2x2, stride 2, signed max; result slot k = ch*(IN_W/2)^2 + (row>>1)*(IN_W/2) + (col>>1); slot k SHALL occupy pool_lin[k*DW +: DW].
REQ-015 Even-column beat SHALL be held in a pair register.
REQ-016 Odd-column beat SHALL form hmax = max(pair, pixel).
REQ-017 For an even row, hmax SHALL be stored in row buffer entry col>>1 (IN_W/2 entries).
REQ-018 For an odd row, slot k SHALL be written with max(rowbuf[col>>1], hmax) in the same cycle.
REQ-019 Throughput SHALL be one beat per cycle; in_valid bubbles SHALL not change results.
REQ-020 The FSM SHALL have two states, COLLECT and FULL.
REQ-021 In COLLECT, in_ready SHALL be 1.
REQ-022 On acceptance of the last beat (ch=CH-1, row=col=IN_W-1), the next state SHALL be FULL.
REQ-023 In FULL, out_valid SHALL be 1 and in_ready 0; pool_lin SHALL be stable.
REQ-024 FULL to COLLECT SHALL occur when out_valid && out_ready; in_ready SHALL be 1 the following cycle.
REQ-025 Latency from last-beat acceptance to out_valid SHALL be exactly 1 cycle.
REQ-026 Counters col/row/ch SHALL wrap to 0 at IN_W-1/IN_W-1/CH-1 respectively.
REQ-027 All counters SHALL be 0 on entry to COLLECT.
REQ-028 pool_lin slots SHALL be overwritten progressively during the next frame; the consumer samples only on the handshake.
REQ-029 The signed max comparison SHALL be exact over the full DW range; no saturation or widening.

Reset
REQ-030 While rst=1, in_ready and out_valid SHALL be 0.
REQ-031 On reset, state SHALL be COLLECT, counters 0, pair and row buffer 0, pool_lin all 0.
REQ-032 in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-033 Reset mid-frame or in FULL SHALL discard the partial or pending volume; no out_valid SHALL result from pre-reset beats.

Structure
REQ-034 A shared package SHALL hold DW, IN_W, CH, POOL_W=IN_W/2, SLOTS=CH*POOL_W^2, the state enum, and the pool_lin width constant, shared with the fully-connected stage.
REQ-035 A single sub-module max2_s8 SHALL perform the combinational signed 2-input max, instantiated twice (horizontal and vertical).

Verification
REQ-036 108 beats of 8'h05, out_ready=1 -> out_valid 1 cycle after beat 108; all 27 slots 8'h05; in_ready 1 again the following cycle.
REQ-037 Ramp pixel = ch*40 + row*6 + col -> slot ch*9 + r*3 + c = ch*40 + (2r+1)*6 + 2c+1 (slot 0 = 7, slot 26 = 115).
REQ-038 Window {-128, -1, -2, -3} in ch0 top-left, all other pixels 8'h80 -> slot 0 = 8'hFF, remaining slots 8'h80.
REQ-039 out_ready=0 for 10 cycles after out_valid -> out_valid held, pool_lin stable, in_ready 0, in_valid beats not accepted; accepted on out_ready=1.
REQ-040 Random in_valid bubbles (~50%) on the ramp frame -> result identical to REQ-037.
REQ-041 rst pulsed after 50 beats, then a full ramp frame -> single out_valid with REQ-037 values; no earlier out_valid.
